fp_addsub_pipe: RTL and testbench
=================================

// Module: fp_addsub_pipe
// PURPOSE
//  Parametrised 3-stage pipelined floating-point add/subtract unit with valid/ready flow control.
//  It generalises the 27-bit adder to any EXP_W/MAN_W and adds these features:
//   - a per-operation subtract mode;
//   - backpressure;
//   - a tag side-band;
//   - overflow/underflow flags.
//  It sits between operand-fetch logic and the result writeback stage in the clk_pll domain.
// PARAMETERS
//  EXP_W  8   exponent width; bias = 2**(EXP_W-1)-1
//  MAN_W  18  stored mantissa width (hidden leading 1 implied); word width W = 1+EXP_W+MAN_W
//  TAG_W  4   opaque side-band tag width, carried alongside each operation
// PORTS
//  clk_pll    in   1      clock; all state updates on its rising edge
//  rst_n      in   1      synchronous reset, active-low
//  in_valid   in   1      operand pair present
//  in_ready   out  1      unit accepts operands this cycle
//  in_a       in   W      operand A {sign, exp, man}
//  in_b       in   W      operand B
//  in_sub     in   1      1: result = A-B; 0: result = A+B
//  in_tag     in   TAG_W  returned unchanged with the result
//  out_valid  out  1      result present
//  out_ready  in   1      consumer takes the result this cycle
//  out_sum    out  W      result word
//  out_tag    out  TAG_W  tag of this result
//  out_ovf    out  1      result saturated (overflow)
//  out_unf    out  1      result flushed to zero (underflow)
// BEHAVIOUR
//  - Format: exp==0 means zero, regardless of mantissa; no subnormals.
//    Exp all-ones is not produced on output; as an input it is treated as an ordinary exponent.
//  - Stage 1: flip the sign of B when in_sub=1; order operands by magnitude;
//    right-shift the smaller mantissa by the exponent difference.
//    Shifted-out bits are kept as guard/round/sticky.
//  - Stage 2: add or subtract the mantissas according to the effective signs; capture the carry.
//  - Stage 3: normalise (carry -> shift right 1, exp+1; else leading-zero shift left, exp-lz),
//    then round, then apply the exception rules below.
//  - Latency: exactly 3 cycles from the accept edge to out_valid, with out_ready held 1.
//    Throughput is 1 operation per cycle.
//  - Flow control is a global stall, en = out_ready | ~out_valid.
//    in_ready = en (combinational).
//    - Accept when in_valid & in_ready.
//    - When en=0 every stage register holds, and out_* stay stable.
//    - Per-stage valid bits propagate bubbles when en=1.
//    - Results leave in issue order.
//  - Overflow: if the normalised exp >= 2**EXP_W-1, out_sum = {sign, 2**EXP_W-2, all-ones man}
//    and out_ovf=1.
//  - Underflow: if the normalised exp < 1, out_sum = 0 and out_unf=1.
//  - Exact cancellation gives out_sum = 0 (+0) with both flags 0.
//  - Zero operand: the result is the other operand, with its sign flipped if it is B and in_sub=1.
//  - out_ovf/out_unf/out_tag are valid only while out_valid=1; they are held with out_sum during a stall.
//  - Reset: on any edge with rst_n=0, all stage valids, out_valid, out_sum, out_tag, out_ovf
//    and out_unf go to 0.
//    In-flight operations are discarded; reset wins over a simultaneous accept.
//  - in_ready is 1 during reset (en=1 because out_valid=0), but no accept occurs on a reset edge.
// CONFIGURATION
//  FP_ADD_RNE_EN defined:
//   - round to nearest, ties to even, using guard/round/sticky;
//   - a mantissa round-up carry renormalises (exp+1) and may cause overflow.
//  FP_ADD_RNE_EN undefined:
//   - truncation (round toward zero); guard/round/sticky logic is not built.
//  Latency and ports are identical in both builds.
// TESTING (defaults, W=27)
//  1) A=0x1FC0000 (1.0) + B=0x2000000 (2.0), sub=0, tag=3
//     -> 3 cycles later: out_sum=0x2020000 (3.0), tag=3, flags 0.
//  2) A=0x1FC0000 - B=0x1FC0000 (sub=1) -> out_sum=0x0000000, ovf=0, unf=0.
//  3) A=B=0x3FBFFFF (max finite), add -> out_sum=0x3FBFFFF, out_ovf=1.
//     A=0x0040000 - B=0x0060000 -> out_sum=0, out_unf=1.
//  4) A=0x1FC0001 + B=0x1B00000 (2^-19):
//     with FP_ADD_RNE_EN -> 0x1FC0002 (tie to even); without it -> 0x1FC0001.
//  5) Issue tags 1,2,3 back to back, then hold out_ready=0 for 5 cycles:
//     - tag 1 held stable on the output, in_ready=0, no accept;
//     - after release, tags 1,2,3 emerge on consecutive cycles with correct sums.
//  6) Pull rst_n low for 1 cycle with 3 operations in flight
//     -> next cycle all outputs 0, and no result from the flushed operations ever appears.

Source files
------------

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: pipelined floating-point add/subtract with a global valid/ready stall and tag side-band.
// Build option FP_ADD_RNE_EN: round to nearest even via guard/round/sticky; undefined means truncation.
module fp_addsub_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 18,
   parameter int TAG_W = 4
) (
   input  logic                   clk_pll,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   in_a,
   input  logic [EXP_W+MAN_W:0]   in_b,
   input  logic                   in_sub,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out_sum,
   output logic [TAG_W-1:0]       out_tag,
   output logic                   out_ovf,
   output logic                   out_unf
);

   localparam int W   = 1 + EXP_W + MAN_W;
`ifdef FP_ADD_RNE_EN
   localparam int GW  = 3;
`else
   localparam int GW  = 0;
`endif
   localparam int MW  = MAN_W + 1 + GW;
   localparam int XW  = EXP_W + 2;
   localparam int LZW = $clog2(MW + 1);

   localparam logic signed [XW-1:0] EXP_TOP = $signed({2'b00, {EXP_W{1'b1}}});
   localparam logic signed [XW-1:0] E_ONE   = $signed({{(XW-1){1'b0}}, 1'b1});
   localparam logic [EXP_W-1:0]     EXP_SAT = {{(EXP_W-1){1'b1}}, 1'b0};

   function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] v);
      logic [LZW-1:0] n;
      logic           found;
      n     = {LZW{1'b0}};
      found = 1'b0;
      for (int i = MW - 1; i >= 0; i--) begin
         if (!found && !v[i]) begin
            n = n + {{(LZW-1){1'b0}}, 1'b1};
         end else begin
            n = n;
         end
         found = found | v[i];
      end
      return n;
   endfunction

   logic en_s;

   logic                 s0_valid_r;
   logic [W-1:0]         s0_a_r;
   logic [W-1:0]         s0_b_r;
   logic                 s0_sub_r;
   logic [TAG_W-1:0]     s0_tag_r;

   logic [EXP_W-1:0]     a_exp_s, b_exp_s, big_exp_s, small_exp_s, diff_s;
   logic [MW-1:0]        a_m_s, b_m_s, big_m_s, small_m_s, small_al_s;
   logic                 b_sign_s, big_sign_s, small_sign_s;
   logic [LZW-1:0]       shamt_s;
`ifdef FP_ADD_RNE_EN
   logic [2*MW-1:0]      wide_s;
`endif

   logic                 s1_valid_r;
   logic                 s1_sign_r;
   logic                 s1_eff_sub_r;
   logic [EXP_W-1:0]     s1_exp_r;
   logic [MW-1:0]        s1_big_m_r;
   logic [MW-1:0]        s1_small_m_r;
   logic [TAG_W-1:0]     s1_tag_r;

   logic [MW:0]          sum_s;

   logic                 s2_valid_r;
   logic                 s2_sign_r;
   logic [EXP_W-1:0]     s2_exp_r;
   logic [MW:0]          s2_sum_r;
   logic [TAG_W-1:0]     s2_tag_r;

   logic [LZW-1:0]       lz_s;
   logic [MW-1:0]        norm_m_s;
   logic signed [XW-1:0] norm_e_s;
   logic signed [XW-1:0] rnd_e_s;
   logic [MAN_W-1:0]     rnd_man_s;
`ifdef FP_ADD_RNE_EN
   logic                 round_up_s;
   logic [MAN_W+1:0]     rnd_m_s;
`endif
   logic [W-1:0]         res_sum_s;
   logic                 res_ovf_s;
   logic                 res_unf_s;

   assign en_s     = out_ready | ~out_valid;
   assign in_ready = en_s;

   // Input capture: operands land here on the accept edge, keeping alignment logic off the ports.
   always_ff @(posedge clk_pll) begin
      if (!rst_n) begin
         s0_valid_r <= 1'b0;
         s0_a_r     <= '0;
         s0_b_r     <= '0;
         s0_sub_r   <= 1'b0;
         s0_tag_r   <= '0;
      end else if (en_s) begin
         s0_valid_r <= in_valid;
         s0_a_r     <= in_a;
         s0_b_r     <= in_b;
         s0_sub_r   <= in_sub;
         s0_tag_r   <= in_tag;
      end
   end

   // Stage 1 logic: effective sign of B, magnitude ordering and alignment of the smaller mantissa.
   always_comb begin
      a_exp_s  = s0_a_r[MAN_W +: EXP_W];
      b_exp_s  = s0_b_r[MAN_W +: EXP_W];
      a_m_s    = (a_exp_s == {EXP_W{1'b0}}) ? {MW{1'b0}} : MW'({1'b1, s0_a_r[MAN_W-1:0]}) << GW;
      b_m_s    = (b_exp_s == {EXP_W{1'b0}}) ? {MW{1'b0}} : MW'({1'b1, s0_b_r[MAN_W-1:0]}) << GW;
      b_sign_s = s0_b_r[W-1] ^ s0_sub_r;
      if ({a_exp_s, a_m_s} >= {b_exp_s, b_m_s}) begin
         big_sign_s   = s0_a_r[W-1];
         small_sign_s = b_sign_s;
         big_exp_s    = a_exp_s;
         small_exp_s  = b_exp_s;
         big_m_s      = a_m_s;
         small_m_s    = b_m_s;
      end else begin
         big_sign_s   = b_sign_s;
         small_sign_s = s0_a_r[W-1];
         big_exp_s    = b_exp_s;
         small_exp_s  = a_exp_s;
         big_m_s      = b_m_s;
         small_m_s    = a_m_s;
      end
      diff_s = big_exp_s - small_exp_s;
      if (32'(diff_s) > 32'(MW)) begin
         shamt_s = LZW'(MW);
      end else begin
         shamt_s = LZW'(diff_s);
      end
`ifdef FP_ADD_RNE_EN
      // Everything shifted below the round bit collapses into the sticky bit.
      wide_s     = {small_m_s, {MW{1'b0}}} >> shamt_s;
      small_al_s = wide_s[2*MW-1:MW] | {{(MW-1){1'b0}}, |wide_s[MW-1:0]};
`else
      small_al_s = small_m_s >> shamt_s;
`endif
   end

   // Stage 1 register.
   always_ff @(posedge clk_pll) begin
      if (!rst_n) begin
         s1_valid_r   <= 1'b0;
         s1_sign_r    <= 1'b0;
         s1_eff_sub_r <= 1'b0;
         s1_exp_r     <= '0;
         s1_big_m_r   <= '0;
         s1_small_m_r <= '0;
         s1_tag_r     <= '0;
      end else if (en_s) begin
         s1_valid_r   <= s0_valid_r;
         s1_sign_r    <= big_sign_s;
         s1_eff_sub_r <= big_sign_s ^ small_sign_s;
         s1_exp_r     <= big_exp_s;
         s1_big_m_r   <= big_m_s;
         s1_small_m_r <= small_al_s;
         s1_tag_r     <= s0_tag_r;
      end
   end

   // Stage 2 logic: big operand never loses in a subtraction, so the difference is non-negative.
   always_comb begin
      if (s1_eff_sub_r) begin
         sum_s = {1'b0, s1_big_m_r} - {1'b0, s1_small_m_r};
      end else begin
         sum_s = {1'b0, s1_big_m_r} + {1'b0, s1_small_m_r};
      end
   end

   // Stage 2 register.
   always_ff @(posedge clk_pll) begin
      if (!rst_n) begin
         s2_valid_r <= 1'b0;
         s2_sign_r  <= 1'b0;
         s2_exp_r   <= '0;
         s2_sum_r   <= '0;
         s2_tag_r   <= '0;
      end else if (en_s) begin
         s2_valid_r <= s1_valid_r;
         s2_sign_r  <= s1_sign_r;
         s2_exp_r   <= s1_exp_r;
         s2_sum_r   <= sum_s;
         s2_tag_r   <= s1_tag_r;
      end
   end

   // Stage 3 logic: normalise, round, then saturate or flush.
   always_comb begin
      lz_s = lzc(s2_sum_r[MW-1:0]);
      if (s2_sum_r[MW]) begin
`ifdef FP_ADD_RNE_EN
         norm_m_s = {s2_sum_r[MW:2], s2_sum_r[1] | s2_sum_r[0]};
`else
         norm_m_s = s2_sum_r[MW:1];
`endif
         norm_e_s = $signed({2'b00, s2_exp_r}) + E_ONE;
      end else begin
         norm_m_s = s2_sum_r[MW-1:0] << lz_s;
         norm_e_s = $signed({2'b00, s2_exp_r}) - $signed({{(XW-LZW){1'b0}}, lz_s});
      end
`ifdef FP_ADD_RNE_EN
      round_up_s = norm_m_s[GW-1] & (norm_m_s[GW-2] | norm_m_s[GW-3] | norm_m_s[GW]);
      rnd_m_s    = {1'b0, norm_m_s[MW-1:GW]} + {{(MAN_W+1){1'b0}}, round_up_s};
      if (rnd_m_s[MAN_W+1]) begin
         rnd_man_s = rnd_m_s[MAN_W:1];
         rnd_e_s   = norm_e_s + E_ONE;
      end else begin
         rnd_man_s = rnd_m_s[MAN_W-1:0];
         rnd_e_s   = norm_e_s;
      end
`else
      rnd_man_s = norm_m_s[MAN_W-1:0];
      rnd_e_s   = norm_e_s;
`endif
      res_sum_s = '0;
      res_ovf_s = 1'b0;
      res_unf_s = 1'b0;
      // A clear hidden bit after normalisation only happens for an all-zero sum.
      if (!norm_m_s[MW-1]) begin
         res_sum_s = '0;
      end else if (rnd_e_s >= EXP_TOP) begin
         res_sum_s = {s2_sign_r, EXP_SAT, {MAN_W{1'b1}}};
         res_ovf_s = 1'b1;
      end else if (rnd_e_s < E_ONE) begin
         res_unf_s = 1'b1;
      end else begin
         res_sum_s = {s2_sign_r, rnd_e_s[EXP_W-1:0], rnd_man_s};
      end
   end

   // Output register: bubbles leave zeroed payload behind.
   always_ff @(posedge clk_pll) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_tag   <= '0;
         out_ovf   <= 1'b0;
         out_unf   <= 1'b0;
      end else if (en_s) begin
         out_valid <= s2_valid_r;
         out_sum   <= s2_valid_r ? res_sum_s : {W{1'b0}};
         out_tag   <= s2_valid_r ? s2_tag_r : {TAG_W{1'b0}};
         out_ovf   <= s2_valid_r & res_ovf_s;
         out_unf   <= s2_valid_r & res_unf_s;
      end
   end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: expected results are queued at accept and compared as results leave.
module tb_fp_addsub_pipe;

   localparam int EXP_W = 8;
   localparam int MAN_W = 18;
   localparam int TAG_W = 4;
   localparam int W     = 1 + EXP_W + MAN_W;

   typedef struct packed {
      logic [W-1:0]     sum;
      logic [TAG_W-1:0] tag;
      logic             ovf;
      logic             unf;
   } exp_t;

   logic             clk_pll = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_a;
   logic [W-1:0]     in_b;
   logic             in_sub;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_sum;
   logic [TAG_W-1:0] out_tag;
   logic             out_ovf;
   logic             out_unf;

   exp_t exp_q[$];
   exp_t cur_exp;
   int   n_checks = 0;
   int   n_fail   = 0;

   fp_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
      .clk_pll  (clk_pll),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_sub   (in_sub),
      .in_tag   (in_tag),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .out_tag  (out_tag),
      .out_ovf  (out_ovf),
      .out_unf  (out_unf)
   );

   always #5 clk_pll = ~clk_pll;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk_pll);
      #1;
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic [TAG_W-1:0] tag, input logic [W-1:0] sum,
                        input logic ovf, input logic unf);
      int g;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_sub   = sub;
      in_tag   = tag;
      cur_exp  = '{sum: sum, tag: tag, ovf: ovf, unf: unf};
      g = 0;
      while (!in_ready && g < 50) begin
         tick();
         g++;
      end
      check("accept_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 100) begin
         tick();
         g++;
      end
      check("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   // Scoreboard: inputs and outputs are stable at the falling edge, so handshakes are decided here.
   always @(negedge clk_pll) begin
      exp_t e;
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
               n_fail++;
               $error("FAIL unexpected_output: observed tag 0x%0h sum 0x%0h expected no result", out_tag, out_sum);
            end
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check($sformatf("sum_tag%0d", e.tag), 32'(out_sum), 32'(e.sum));
               check($sformatf("tag_tag%0d", e.tag), 32'(out_tag), 32'(e.tag));
               check($sformatf("ovf_tag%0d", e.tag), 32'(out_ovf), 32'(e.ovf));
               check($sformatf("unf_tag%0d", e.tag), 32'(out_unf), 32'(e.unf));
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(cur_exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_a      = 27'h1FC0000;
      in_b      = 27'h1FC0000;
      in_sub    = 1'b0;
      in_tag    = 4'd15;
      out_ready = 1'b0;
      cur_exp   = '0;
      tick();
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_sum", 32'(out_sum), 32'd0);
      check("rst_out_tag", 32'(out_tag), 32'd0);
      check("rst_flags", 32'({out_ovf, out_unf}), 32'd0);
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();

      // 1.0 + 2.0 with exact three-cycle latency
      issue(27'h1FC0000, 27'h2000000, 1'b0, 4'd3, 27'h2020000, 1'b0, 1'b0);
      check("lat_edge0", 32'(out_valid), 32'd0);
      tick();
      check("lat_edge1", 32'(out_valid), 32'd0);
      tick();
      check("lat_edge2", 32'(out_valid), 32'd0);
      tick();
      check("lat_edge3", 32'(out_valid), 32'd1);
      check("lat_tag", 32'(out_tag), 32'd3);
      drain();

      // Back-to-back directed operations
      issue(27'h1FC0000, 27'h1FC0000, 1'b1, 4'd4, 27'h0000000, 1'b0, 1'b0);
      issue(27'h3FBFFFF, 27'h3FBFFFF, 1'b0, 4'd5, 27'h3FBFFFF, 1'b1, 1'b0);
      issue(27'h0040000, 27'h0060000, 1'b1, 4'd6, 27'h0000000, 1'b0, 1'b1);
`ifdef FP_ADD_RNE_EN
      issue(27'h1FC0001, 27'h1B00000, 1'b0, 4'd7, 27'h1FC0002, 1'b0, 1'b0);
`else
      issue(27'h1FC0001, 27'h1B00000, 1'b0, 4'd7, 27'h1FC0001, 1'b0, 1'b0);
`endif
      issue(27'h2020000, 27'h1FC0000, 1'b1, 4'd8, 27'h2000000, 1'b0, 1'b0);
      issue(27'h1FC0000, 27'h1FA0000, 1'b1, 4'd9, 27'h1F40000, 1'b0, 1'b0);
      issue(27'h0000000, 27'h2000000, 1'b1, 4'd10, 27'h6000000, 1'b0, 1'b0);
      issue(27'h2000000, 27'h0000000, 1'b0, 4'd11, 27'h2000000, 1'b0, 1'b0);
      issue(27'h5FC0000, 27'h2000000, 1'b0, 4'd12, 27'h1FC0000, 1'b0, 1'b0);
      issue(27'h1FC0000, 27'h1840000, 1'b0, 4'd13, 27'h1FC0000, 1'b0, 1'b0);
      issue(27'h3FC0000, 27'h3F80000, 1'b1, 4'd14, 27'h3F80000, 1'b0, 1'b0);
      issue(27'h5FC0000, 27'h1FC0000, 1'b0, 4'd15, 27'h0000000, 1'b0, 1'b0);
      drain();
      tick();

      // Backpressure: three in flight, consumer stalls for five cycles
      out_ready = 1'b0;
      issue(27'h1FC0000, 27'h2000000, 1'b0, 4'd1, 27'h2020000, 1'b0, 1'b0);
      issue(27'h2020000, 27'h1FC0000, 1'b1, 4'd2, 27'h2000000, 1'b0, 1'b0);
      issue(27'h1FC0000, 27'h1FA0000, 1'b1, 4'd3, 27'h1F40000, 1'b0, 1'b0);
      tick();
      in_valid = 1'b1;
      in_a     = 27'h2000000;
      in_b     = 27'h2000000;
      in_tag   = 4'd9;
      for (int i = 0; i < 5; i++) begin
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_tag", 32'(out_tag), 32'd1);
         check("stall_sum", 32'(out_sum), 32'h2020000);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("release_tag2", 32'({out_valid, out_tag}), 32'h12);
      tick();
      check("release_tag3", 32'({out_valid, out_tag}), 32'h13);
      tick();
      check("release_empty", 32'(out_valid), 32'd0);
      drain();

      // Reset with three operations in flight and an accept attempted on the reset edge
      issue(27'h1FC0000, 27'h2000000, 1'b0, 4'd4, 27'h2020000, 1'b0, 1'b0);
      issue(27'h1FC0000, 27'h2000000, 1'b0, 4'd5, 27'h2020000, 1'b0, 1'b0);
      issue(27'h1FC0000, 27'h2000000, 1'b0, 4'd6, 27'h2020000, 1'b0, 1'b0);
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_tag   = 4'd7;
      tick();
      rst_n    = 1'b1;
      in_valid = 1'b0;
      check("flush_valid", 32'(out_valid), 32'd0);
      check("flush_sum", 32'(out_sum), 32'd0);
      check("flush_tag", 32'(out_tag), 32'd0);
      check("flush_flags", 32'({out_ovf, out_unf}), 32'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("flush_quiet", 32'(out_valid), 32'd0);
      end
      check("flush_queue", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
